alu32_pipe: RTL and testbench
=============================

Name: alu32_pipe

Overview:
Registered, handshaked execution stage wrapped around the team's combinational alu32 block. It buffers incoming operand/opcode commands in a small FIFO and presents the FIFO head to alu32. The result and flags are captured into an output register with valid/ready backpressure. It sits between the operand-fetch/issue logic (upstream) and writeback/flag consumers (downstream).

Parameters:
DEPTH, 2, input FIFO entries; power of 2, minimum 2
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream command valid
in_ready  output  1  FIFO can accept; equals !full
in_a  input  32  operand a
in_b  input  32  operand b
in_op  input  3  opcode
out_valid  output  1  output register holds a result
out_ready  input  1  downstream accepts result
out_result  output  32  registered result
out_c  output  1  registered carry flag
out_n  output  1  registered negative flag
out_z  output  1  registered zero flag
out_v  output  1  registered overflow flag
op_count  output  CNT_W  number of results loaded into output register
clr_sticky  input  1  synchronous sticky clear (macro only)
sticky_c  output  1  accumulated carry (macro only)
sticky_v  output  1  accumulated overflow (macro only)

Behaviour:
- Reset: asynchronous and active-high. Name the clock and reset ports clk and reset. Effects:
  - FIFO is emptied, in_ready=1.
  - out_valid=0, out_result=0, all out flags=0, op_count=0, sticky bits=0.
  - Reset mid-operation discards all buffered and pending commands.
- Opcode map (alu32):
  - 000 ~a; 001 ~b; 010 a&b; 011 a|b; 100 a^b; 101 ~(a^b); 110 a+b; 111 a-b (a+~b+1).
- Flags:
  - n=result[31]; z=(result==0).
  - c = adder carry-out for 110/111 (for 111, c=1 means no borrow); 0 for logic ops.
  - v = signed overflow (carry into bit31 XOR carry out of bit31) for 110/111; 0 for logic ops.
- Push: on in_valid && in_ready, {a,b,op} is written at wr_ptr and count increments.
  - in_ready depends only on registered count; there is no combinational path from out_ready.
- Load condition: load = FIFO non-empty && (!out_valid || out_ready).
  - On load, the head is popped, alu32 output and flags are registered, out_valid=1, and op_count increments (wraps at 2^CNT_W).
- If out_valid && out_ready && FIFO empty: out_valid goes to 0. out_result and flags hold their last values.
- If out_valid && !out_ready: out_result, flags, and out_valid hold stable.
- Latency: a command accepted at edge N with an empty FIFO and free output appears with out_valid=1 after edge N+1.
  - Throughput is 1 result per clock when out_ready=1.
- Simultaneous push and pop in one cycle: allowed when not full. Count is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from a separate count register (0..DEPTH).
- Ordering: results exit strictly in acceptance order.

Optional Feature:
ALU32_PIPE_STICKY_EN
- Defined:
  - Ports clr_sticky, sticky_c, and sticky_v exist.
  - On each load, sticky_c |= out_c_next and sticky_v |= out_v_next.
  - clr_sticky=1 clears both bits at the next edge. If a load in the same cycle sets a bit, set wins.
- Undefined: those ports and registers are absent. All other behaviour is identical.

Test Plan:
- Add overflow: reset, push a=0x7FFFFFFF, b=0x00000001, op=110 with out_ready=1 -> one cycle later result=0x80000000, n=1, v=1, c=0, z=0, op_count=1.
- Carry and zero: push a=0xFFFFFFFF, b=1, op=110 -> result=0, c=1, z=1, v=0. Then push a=5, b=5, op=111 -> result=0, c=1, z=1, n=0, v=0.
- Logic op: push a=0xF0F0F0F0, b=0xFF00FF00, op=010 -> result=0xF000F000, n=1, c=0, v=0. Then op=000 with a=0 -> result=0xFFFFFFFF.
- Backpressure (DEPTH=2): hold out_ready=0 and push 3 commands. The first loads into the output, 2 fill the FIFO, and in_ready=0 with out_result stable. Then set out_ready=1 -> the 3 results emerge in order on consecutive cycles, in_ready returns to 1, and op_count=3.
- Reset mid-operation: with FIFO full and out_valid=1, assert reset asynchronously between edges -> out_valid=0, in_ready=1, op_count=0 immediately. No stale result appears after release.
- Sticky (macro defined): run the overflow add, then a logic op -> sticky_v stays 1. Pulse clr_sticky together with another overflowing add -> sticky_v remains 1. Pulse clr_sticky alone -> sticky_v=0.

Source files
------------

// File: rtl/alu32_pipe.sv
// ============================================================================
//  Module      : alu32_pipe (with combinational alu32)
//  Description : Handshaked ALU execution stage. Commands are buffered in a
//                DEPTH-entry FIFO; the FIFO head feeds alu32 and the result
//                plus C/N/Z/V flags are captured in a valid/ready output
//                register. op_count counts results loaded into that register.
//  Options     : `define ALU32_PIPE_STICKY_EN adds sticky carry/overflow bits
//                (ports clr_sticky, sticky_c, sticky_v).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_result,
  output logic        o_c,
  output logic        o_n,
  output logic        o_z,
  output logic        o_v
);
  logic [31:0] w_b_eff;
  logic [32:0] w_sum;
  logic        w_c31;

  // Shared adder: subtraction is a + ~b + 1, selected by op[0] within 11x.
  assign w_b_eff = i_op[0] ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, i_op[0]};
  // Carry into bit 31 recovered from the sum bit and its two operand bits.
  assign w_c31   = i_a[31] ^ w_b_eff[31] ^ w_sum[31];

  // Opcode decode and flag generation.
  always_comb begin
    o_result = 32'd0;
    o_c      = 1'b0;
    o_v      = 1'b0;
    case (i_op)
      3'b000: o_result = ~i_a;
      3'b001: o_result = ~i_b;
      3'b010: o_result = i_a & i_b;
      3'b011: o_result = i_a | i_b;
      3'b100: o_result = i_a ^ i_b;
      3'b101: o_result = ~(i_a ^ i_b);
      default: begin
        o_result = w_sum[31:0];
        o_c      = w_sum[32];
        o_v      = w_c31 ^ w_sum[32];
      end
    endcase
    o_n = o_result[31];
    o_z = (o_result == 32'd0);
  end
endmodule

module alu32_pipe #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_c,
  output logic             out_n,
  output logic             out_z,
  output logic             out_v,
  output logic [CNT_W-1:0] op_count
`ifdef ALU32_PIPE_STICKY_EN
  ,
  input  logic             clr_sticky,
  output logic             sticky_c,
  output logic             sticky_v
`endif
);
  localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE   = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
  localparam logic [CNT_W-1:0]   c_OPC_ONE   = CNT_W'(1);

  logic [31:0]      r_mem_a  [0:DEPTH-1];
  logic [31:0]      r_mem_b  [0:DEPTH-1];
  logic [2:0]       r_mem_op [0:DEPTH-1];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic             r_out_valid;
  logic [31:0]      r_result;
  logic             r_c, r_n, r_z, r_v;
  logic [CNT_W-1:0] r_op_count;

  logic             w_full, w_empty, w_push, w_load;
  logic [31:0]      w_alu_result;
  logic             w_alu_c, w_alu_n, w_alu_z, w_alu_v;

  // Full/empty come only from the registered count, so in_ready never
  // depends combinationally on out_ready.
  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_load  = !w_empty && (!r_out_valid || out_ready);

  alu32 u_alu32 (
    .i_a      (r_mem_a[r_rd_ptr]),
    .i_b      (r_mem_b[r_rd_ptr]),
    .i_op     (r_mem_op[r_rd_ptr]),
    .o_result (w_alu_result),
    .o_c      (w_alu_c),
    .o_n      (w_alu_n),
    .o_z      (w_alu_z),
    .o_v      (w_alu_v)
  );

  // FIFO storage: written at wr_ptr on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= in_a;
      r_mem_b[r_wr_ptr]  <= in_b;
      r_mem_op[r_wr_ptr] <= in_op;
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_load) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: load the FIFO head when the slot is free or draining;
  // otherwise hold, dropping valid once a result is taken with nothing behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_c         <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_v         <= 1'b0;
      r_op_count  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_result;
      r_c         <= w_alu_c;
      r_n         <= w_alu_n;
      r_z         <= w_alu_z;
      r_v         <= w_alu_v;
      r_op_count  <= r_op_count + c_OPC_ONE;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = !w_full;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_c      = r_c;
  assign out_n      = r_n;
  assign out_z      = r_z;
  assign out_v      = r_v;
  assign op_count   = r_op_count;

`ifdef ALU32_PIPE_STICKY_EN
  logic r_sticky_c, r_sticky_v;

  // Sticky flags accumulate on each load; a set from a load beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky_c <= 1'b0;
      r_sticky_v <= 1'b0;
    end else if (clr_sticky) begin
      r_sticky_c <= w_load && w_alu_c;
      r_sticky_v <= w_load && w_alu_v;
    end else if (w_load) begin
      r_sticky_c <= r_sticky_c | w_alu_c;
      r_sticky_v <= r_sticky_v | w_alu_v;
    end
  end

  assign sticky_c = r_sticky_c;
  assign sticky_v = r_sticky_v;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu32_pipe.sv
// ============================================================================
//  Module      : tb_alu32_pipe
//  Description : Directed bench for alu32_pipe with an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu32_pipe;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] result;
    logic        c;
    logic        n;
    logic        z;
    logic        v;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a, in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_c, out_n, out_z, out_v;
  logic [CNT_W-1:0] op_count;
`ifdef ALU32_PIPE_STICKY_EN
  logic             clr_sticky;
  logic             sticky_c, sticky_v;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu32_pipe #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_c      (out_c),
    .out_n      (out_n),
    .out_z      (out_z),
    .out_v      (out_v),
    .op_count   (op_count)
`ifdef ALU32_PIPE_STICKY_EN
    ,
    .clr_sticky (clr_sticky),
    .sticky_c   (sticky_c),
    .sticky_v   (sticky_v)
`endif
  );

  // Reference ALU: overflow from operand/result signs, not from carries.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    case (op)
      3'd0: e.result = ~a;
      3'd1: e.result = ~b;
      3'd2: e.result = a & b;
      3'd3: e.result = a | b;
      3'd4: e.result = a ^ b;
      3'd5: e.result = ~(a ^ b);
      3'd6: begin
        s        = {1'b0, a} + {1'b0, b};
        e.result = s[31:0];
        e.c      = s[32];
        e.v      = (a[31] == b[31]) && (s[31] != a[31]);
      end
      default: begin
        s        = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.result = s[31:0];
        e.c      = (a >= b);
        e.v      = (a[31] != b[31]) && (s[31] != a[31]);
      end
    endcase
    e.n = e.result[31];
    e.z = (e.result == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every result the downstream accepts is checked against the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_output: observed=%h expected=none", out_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_flags", {28'd0, out_result, out_c, out_n, out_z, out_v}, {28'd0, e});
      end
    end
  end

  // Present one command and hold it until the DUT accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int waited;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    waited   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: observed in_ready=%b expected=1", in_ready);
    end else begin
      @(posedge clk);
      sb_q.push_back(model(a, b, op));
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb_q.size() != 0 || out_valid === 1'b1) && waited < 50) begin
      @(posedge clk);
      #1 waited++;
    end
    check("drain_done", {63'd0, (sb_q.size() == 0 && out_valid === 1'b0)}, 64'd1);
  endtask

  initial begin
    logic [CNT_W-1:0] base;
    logic [31:0]      held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;
`ifdef ALU32_PIPE_STICKY_EN
    clr_sticky = 1'b0;
`endif
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_result",    {32'd0, out_result}, 64'd0);
    check("rst_flags",     {60'd0, out_c, out_n, out_z, out_v}, 64'd0);
    check("rst_op_count",  {48'd0, op_count}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Overflowing add with single-cycle latency.
    send(32'h7FFF_FFFF, 32'h0000_0001, 3'b110);
    check("lat_valid_before", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid_after", {63'd0, out_valid}, 64'd1);
    check("ovf_result", {28'd0, out_result, out_c, out_n, out_z, out_v},
          {28'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    check("ovf_op_count", {48'd0, op_count}, 64'd1);
    drain();

    // Carry/zero, subtraction and logic patterns, back to back.
    send(32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
    send(32'd5,         32'd5,         3'b111);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010);
    send(32'h0000_0000, 32'h1234_5678, 3'b000);
    send(32'd3,         32'd5,         3'b111);
    send(32'h8000_0000, 32'd1,         3'b111);
    send(32'h1234_5678, 32'h0F0F_0F0F, 3'b011);
    send(32'h1234_5678, 32'h1234_5678, 3'b100);
    send(32'h0000_FFFF, 32'hFFFF_0000, 3'b101);
    send(32'h0,         32'h5555_AAAA, 3'b001);
    drain();
    check("op_count_11", {48'd0, op_count}, 64'd11);

    // Backpressure: three commands, output stalled.
    base      = op_count;
    out_ready = 1'b0;
    send(32'd10, 32'd1, 3'b110);
    send(32'd20, 32'd2, 3'b111);
    send(32'd30, 32'd3, 3'b100);
    @(posedge clk);
    #1;
    held = out_result;
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid",    {63'd0, out_valid}, 64'd1);
    check("bp_first_result", {32'd0, out_result}, 64'd11);
    repeat (2) @(posedge clk);
    #1;
    check("bp_result_stable", {32'd0, out_result}, {32'd0, held});
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_consecutive_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;
      if (i == 0) check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    end
    check("bp_drained_valid", {63'd0, out_valid}, 64'd0);
    check("bp_op_count", {48'd0, op_count}, {48'd0, base + CNT_W'(3)});
    drain();

    // Asynchronous reset with FIFO full and output occupied.
    out_ready = 1'b0;
    send(32'd1, 32'd1, 3'b110);
    send(32'd2, 32'd2, 3'b110);
    send(32'd3, 32'd3, 3'b110);
    @(posedge clk);
    #1;
    check("pre_rst_full", {62'd0, in_ready, out_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    check("arst_op_count",  {48'd0, op_count},  64'd0);
    check("arst_result",    {32'd0, out_result}, 64'd0);
    sb_q.delete();
    #2 reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_output", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'h0000_0010, 32'h0000_0020, 3'b111);
    drain();
    check("post_rst_op_count", {48'd0, op_count}, 64'd1);

`ifdef ALU32_PIPE_STICKY_EN
    send(32'h7FFF_FFFF, 32'd1, 3'b110);
    drain();
    check("sticky_v_set", {63'd0, sticky_v}, 64'd1);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010);
    drain();
    check("sticky_v_hold", {63'd0, sticky_v}, 64'd1);
    send(32'h7FFF_FFFF, 32'd1, 3'b110);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    check("sticky_set_wins", {63'd0, sticky_v}, 64'd1);
    drain();
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    check("sticky_cleared", {62'd0, sticky_c, sticky_v}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
